// File: rtl/test_ram_wait.sv
// -----------------------------------------------------------------------------
// test_ram_wait
//   Single-port word RAM with a fixed number of wait states per access.
//   The RAM accepts a request while idle and captures it. It stays busy for
//   WAIT_CYCLES+1 clocks. It then performs the access and pulses data_ready
//   for one cycle.
//
//   Parameters
//     ADDR_WIDTH  : address bus width
//     DATA_WIDTH  : data word width
//     DEPTH       : number of implemented words (addr >= DEPTH is out of range)
//     WAIT_CYCLES : added wait states per access (0..15)
//     WP_BASE     : first write-protected address. It is used only when the
//                   write-protect option is built in.
//
//   Build option
//     TEST_RAM_WRITE_PROTECT_EN : when defined, writes to WP_BASE <= addr < DEPTH
//                                 are dropped but still complete normally.
//
//   Ports
//     clk        : clock, rising edge
//     rst        : asynchronous reset, active low
//     req        : access request, sampled while idle
//     we         : 1 = write, 0 = read (sampled with req)
//     addr       : word address (sampled with req)
//     data_in    : write data (sampled with req)
//     data_out   : registered read data, held until the next read completes
//     data_ready : registered one-cycle completion pulse
//     busy       : high while an access is in progress
// -----------------------------------------------------------------------------
module test_ram_wait #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int WP_BASE     = DEPTH - 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_ready,
   output logic                  busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // One extra bit so that DEPTH == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] WP_BASE_X = (ADDR_WIDTH+1)'(WP_BASE);
   localparam logic [3:0]          WAIT_LD   = 4'(WAIT_CYCLES);

`ifdef TEST_RAM_WRITE_PROTECT_EN
   localparam bit WP_EN = 1'b1;
`else
   localparam bit WP_EN = 1'b0;
`endif

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] din_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  accept;
   logic                  done;
   logic                  in_range;
   logic                  wp_hit;
   logic                  wr_en;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] rd_word;

   assign accept   = (state == IDLE) && req;
   assign done     = (state == BUSY) && (cnt == 4'd0);
   assign in_range = {1'b0, addr_q} < DEPTH_X;
   assign wp_hit   = WP_EN && ({1'b0, addr_q} >= WP_BASE_X);
   assign wr_en    = done && we_q && in_range && !wp_hit;
   assign idx      = addr_q[IDX_W-1:0];
   // Out-of-range reads return all ones and do not touch the array.
   assign rd_word  = in_range ? mem[idx] : '1;

   // ---------------------------------------------------------------- state register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // ---------------------------------------------------------------- next state
   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req)  state_nxt = BUSY;
         BUSY:    if (done) state_nxt = IDLE;
         default:           state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy = (state == BUSY);
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= 4'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         data_ready <= 1'b0;
         data_out   <= '0;
      end else begin
         if (accept) begin
            we_q   <= we;
            addr_q <= addr;
            din_q  <= data_in;
            cnt    <= WAIT_LD;
         end else if ((state == BUSY) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         data_ready <= done;
         if (done && !we_q) data_out <= rd_word;
      end
   end

   // ---------------------------------------------------------------- storage
   // NOTE: the array has no reset. Its contents survive rst. An access aborted by
   // reset never writes, because wr_en depends on state and state is forced to IDLE.
   always_ff @(posedge clk) begin
      if (wr_en) mem[idx] <= din_q;
   end

endmodule

// File: tb/tb_test_ram_wait.sv
// -----------------------------------------------------------------------------
// tb_test_ram_wait
//   Directed bench for test_ram_wait.
//   dut  : WAIT_CYCLES = 2 (default parameters)
//   dut0 : WAIT_CYCLES = 0, used for back-to-back streaming
//   Inputs are driven on the falling edge, and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_test_ram_wait;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       req = 1'b0, we = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic       rdy, bsy;

   logic       req0 = 1'b0, we0 = 1'b0;
   logic [15:0] addr0 = '0;
   logic [7:0] din0 = '0;
   logic [7:0] dout0;
   logic       rdy0, bsy0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   test_ram_wait dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .data_in(din),
      .data_out(dout), .data_ready(rdy), .busy(bsy)
   );

   test_ram_wait #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .data_in(din0),
      .data_out(dout0), .data_ready(rdy0), .busy(bsy0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one access on dut (sel=0) or dut0 (sel=1).
   // Then wait, with a bound, for data_ready and check the latency.
   task automatic acc(input int sel, input logic w, input logic [15:0] a,
                      input logic [7:0] d, input int lat, input string tag,
                      output logic [7:0] q);
      int n;
      if (sel == 0) begin req = 1'b1; we = w; addr = a; din = d; end
      else          begin req0 = 1'b1; we0 = w; addr0 = a; din0 = d; end
      tick();
      req  = 1'b0;
      req0 = 1'b0;
      n = 0;
      while (!((sel == 0) ? rdy : rdy0) && n < 20) begin
         tick();
         n++;
      end
      check({tag, ".lat"}, 32'(n), 32'(lat));
      q = (sel == 0) ? dout : dout0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] q;
      int pulses;

      // ---------------- reset state
      #2 rst = 1'b0;
      #1;
      check("rst.busy", 32'(bsy), 32'd0);
      check("rst.rdy",  32'(rdy), 32'd0);
      check("rst.dout", 32'(dout), 32'd0);
      check("rst.dout0", 32'(dout0), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("idle.busy", 32'(bsy), 32'd0);

      // ---------------- write 0x5A to 0x0010 and trace busy/data_ready
      req = 1'b1; we = 1'b1; addr = 16'h0010; din = 8'h5A;
      tick();                                   // edge 0 accepts
      req = 1'b0;
      check("w.e0.busy", 32'(bsy), 32'd1);
      check("w.e0.rdy",  32'(rdy), 32'd0);
      tick();
      check("w.e1.busy", 32'(bsy), 32'd1);
      check("w.e1.rdy",  32'(rdy), 32'd0);
      tick();
      check("w.e2.busy", 32'(bsy), 32'd1);
      check("w.e2.rdy",  32'(rdy), 32'd0);
      tick();
      check("w.e3.busy", 32'(bsy), 32'd0);
      check("w.e3.rdy",  32'(rdy), 32'd1);
      tick();
      check("w.e4.rdy",  32'(rdy), 32'd0);

      acc(0, 1'b0, 16'h0010, 8'h00, 3, "rd10", q);
      check("rd10.data", 32'(q), 32'h5A);
      tick();
      check("rd10.pulse", 32'(rdy), 32'd0);

      // Writes leave data_out unchanged.
      acc(0, 1'b1, 16'h0000, 8'h44, 3, "wr00", q);
      check("wr00.hold", 32'(dout), 32'h5A);

      // ---------------- req while busy is ignored
      req = 1'b1; we = 1'b1; addr = 16'h0020; din = 8'h3C;
      tick();
      din = 8'hC3;                              // second request while busy
      tick();
      req = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (rdy) pulses++;
         tick();
      end
      check("ign.pulses", 32'(pulses), 32'd1);
      acc(0, 1'b0, 16'h0020, 8'h00, 3, "rd20", q);
      check("rd20.data", 32'(q), 32'h3C);

      // ---------------- out of range
      acc(0, 1'b0, 16'h0400, 8'h00, 3, "rd400", q);
      check("rd400.data", 32'(q), 32'hFF);
      acc(0, 1'b1, 16'h0400, 8'h12, 3, "wr400", q);
      acc(0, 1'b0, 16'h0000, 8'h00, 3, "rd00", q);
      check("rd00.alias", 32'(q), 32'h44);

      // ---------------- reset aborts an in-progress write
      acc(0, 1'b1, 16'h0030, 8'h33, 3, "wr30", q);
      acc(0, 1'b0, 16'h0030, 8'h00, 3, "rd30a", q);
      check("rd30a.data", 32'(q), 32'h33);
      req = 1'b1; we = 1'b1; addr = 16'h0030; din = 8'h77;
      tick();
      req = 1'b0;
      tick();
      #1 rst = 1'b0;
      #1;
      check("abort.busy", 32'(bsy), 32'd0);
      check("abort.rdy",  32'(rdy), 32'd0);
      check("abort.dout", 32'(dout), 32'd0);
      repeat (3) tick();
      check("inrst.rdy",  32'(rdy), 32'd0);
      check("inrst.dout", 32'(dout), 32'd0);
      rst = 1'b1;
      tick();
      tick();
      check("post.busy", 32'(bsy), 32'd0);
      check("post.rdy",  32'(rdy), 32'd0);
      acc(0, 1'b0, 16'h0030, 8'h00, 3, "rd30b", q);
      check("rd30b.data", 32'(q), 32'h33);

      // ---------------- write protect region (WP_BASE = 0x300)
      acc(0, 1'b1, 16'h02FF, 8'h5C, 3, "wr2ff", q);
      acc(0, 1'b0, 16'h02FF, 8'h00, 3, "rd2ff", q);
      check("rd2ff.data", 32'(q), 32'h5C);
      acc(0, 1'b1, 16'h0300, 8'hAA, 3, "wr300", q);
      acc(0, 1'b0, 16'h0300, 8'h00, 3, "rd300", q);
`ifdef TEST_RAM_WRITE_PROTECT_EN
      check("rd300.prot", 32'(q !== 8'hAA), 32'd1);
`else
      check("rd300.data", 32'(q), 32'hAA);
`endif

      // ---------------- zero wait states, back-to-back reads
      acc(1, 1'b1, 16'h0001, 8'hA1, 1, "z.wr1", q);
      acc(1, 1'b1, 16'h0002, 8'hB2, 1, "z.wr2", q);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
      tick();
      check("z.a.busy", 32'(bsy0), 32'd1);
      check("z.a.rdy",  32'(rdy0), 32'd0);
      tick();
      check("z.b.rdy",  32'(rdy0), 32'd1);
      check("z.b.busy", 32'(bsy0), 32'd0);
      check("z.b.data", 32'(dout0), 32'hA1);
      addr0 = 16'h0002;
      tick();
      check("z.c.rdy",  32'(rdy0), 32'd0);
      check("z.c.busy", 32'(bsy0), 32'd1);
      tick();
      check("z.d.rdy",  32'(rdy0), 32'd1);
      check("z.d.data", 32'(dout0), 32'hB2);
      req0 = 1'b0;
      tick();
      check("z.e.rdy",  32'(rdy0), 32'd0);
      check("z.e.busy", 32'(bsy0), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
